// File: rtl/crp_lbuf_pack.sv
// ---------------------------------------------------------------------------
// crp_lbuf_pack
//
// Cropper-side line buffer in front of the AXI4 video write controller.
// 32-bit pixels are packed sixteen to a 512-bit word (pixel 0 in the LSBs)
// and whole lines are held in a two-bank ping-pong RAM. The read side offers
// one complete line at a time through the ST/REN/RCMP/RD handshake and emits
// the frame-start pulse only between lines, never while a line is draining.
//
// Optional feature macro: CRP_LBUF_STAT_EN adds the LBUF_DROP_CNT and
// LBUF_LINE_CNT statistics outputs.
//
// Ports
//   CLK_MIG1_UI       MIG UI clock (only clock)
//   RST               synchronous reset, active high
//   REG_VACT_EN_MIG1  video active enable; low flushes the buffer
//   VIN_DE/SOF/EOL    pixel valid, frame start, line end (SOF/EOL need DE)
//   VIN_DATA          32-bit pixel
//   CRP1_SOF          one-cycle frame-start pulse
//   CRP1_LBUF_ST      a complete line is readable
//   CRP1_LBUF_REN     read one word (RD valid on the next cycle)
//   CRP1_LBUF_RCMP    line read complete, releases the head bank
//   CRP1_LBUF_RD      512-bit read data
//   LBUF_OVF          sticky: a line was dropped, both banks full
//   LBUF_LEN_ERR      sticky: a line exceeded P_LINE_WORDS words
//   LBUF_DROP_CNT     (stat) saturating count of dropped lines
//   LBUF_LINE_CNT     (stat) lines committed in the current frame
// ---------------------------------------------------------------------------
module crp_lbuf_pack #(
    parameter logic       P_SIM          = 1'b0,
    parameter logic [7:0] P_LINE_WORDS   = P_SIM ? 8'd16 : 8'd240,
    parameter int         P_PIX_PER_WORD = 16
) (
    input  logic         CLK_MIG1_UI,
    input  logic         RST,
    input  logic         REG_VACT_EN_MIG1,
    input  logic         VIN_DE,
    input  logic         VIN_SOF,
    input  logic         VIN_EOL,
    input  logic [31:0]  VIN_DATA,
    output logic         CRP1_SOF,
    output logic         CRP1_LBUF_ST,
    input  logic         CRP1_LBUF_REN,
    input  logic         CRP1_LBUF_RCMP,
    output logic [511:0] CRP1_LBUF_RD,
    output logic         LBUF_OVF,
`ifdef CRP_LBUF_STAT_EN
    output logic [15:0]  LBUF_DROP_CNT,
    output logic [11:0]  LBUF_LINE_CNT,
`endif
    output logic         LBUF_LEN_ERR
);

    localparam int                LANE_W    = $clog2(P_PIX_PER_WORD);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(P_PIX_PER_WORD - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SOF, R_RDY}   rstate_t;

    wstate_t           w_state_q;
    rstate_t           r_state_q;
    logic              wbank_q;
    logic              head_q;
    logic [1:0]        bank_vld_q;
    logic [1:0]        bank_sof_q;
    logic [1:0][7:0]   bank_len_q;
    logic [LANE_W-1:0] lane_q;
    logic [511:0]      pack_q;
    logic [7:0]        wcnt_q;
    logic              sof_first_q;
    logic [7:0]        ridx_q;
    logic              rd_vld_q;
    logic [511:0]      ram_rd_q;
    logic              sof_q;
    logic              st_q;
    logic              ovf_q;
    logic              len_err_q;

    // Bank index in the MSB, word index below it.
    logic [511:0] mem [512];

    logic         clr;
    logic         pix_acc;
    logic         word_done;
    logic         ram_we;
    logic         commit;
    logic         line_sof;
    logic         ren_acc;
    logic         rd_in_range;
    logic [511:0] word_d;
    logic [7:0]   wcnt_d;
    logic [7:0]   len_d;

    // Current pixel dropped into its lane on top of the partially packed word;
    // lanes above the current one are still zero because pack_q is cleared
    // after every RAM write, which gives the zero padding on a short last word.
    generate
        for (genvar gi = 0; gi < P_PIX_PER_WORD; gi++) begin : g_lane
            assign word_d[32*gi +: 32] = (lane_q == LANE_W'(gi)) ? VIN_DATA
                                                                 : pack_q[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        clr       = RST | ~REG_VACT_EN_MIG1;
        // The first pixel of a line is consumed in W_IDLE when a bank is free.
        pix_acc   = VIN_DE & (((w_state_q == W_IDLE) & ~bank_vld_q[wbank_q]) |
                              (w_state_q == W_FILL));
        word_done = pix_acc & (VIN_EOL | (lane_q == LANE_LAST));
        ram_we    = word_done & (wcnt_q < P_LINE_WORDS) & ~clr;
        wcnt_d    = wcnt_q;
        if (word_done && (wcnt_q != 8'hFF)) begin
            wcnt_d = wcnt_q + 8'd1;
        end
        len_d       = (wcnt_d > P_LINE_WORDS) ? P_LINE_WORDS : wcnt_d;
        commit      = pix_acc & VIN_EOL;
        line_sof    = (w_state_q == W_IDLE) ? VIN_SOF : sof_first_q;
        ren_acc     = CRP1_LBUF_REN & (r_state_q == R_RDY) & ~clr;
        rd_in_range = ridx_q < bank_len_q[head_q];
    end

    always_ff @(posedge CLK_MIG1_UI) begin
        if (ram_we) begin
            mem[{wbank_q, wcnt_q}] <= word_d;
        end
        if (ren_acc) begin
            ram_rd_q <= mem[{head_q, ridx_q}];
        end
    end

    always_ff @(posedge CLK_MIG1_UI) begin
        if (clr) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            wbank_q     <= 1'b0;
            head_q      <= 1'b0;
            bank_vld_q  <= '0;
            bank_sof_q  <= '0;
            bank_len_q  <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            wcnt_q      <= '0;
            sof_first_q <= 1'b0;
            ridx_q      <= '0;
            rd_vld_q    <= 1'b0;
            sof_q       <= 1'b0;
            st_q        <= 1'b0;
            ovf_q       <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            // ---------------- write side ----------------
            case (w_state_q)
                W_IDLE: begin
                    if (VIN_DE) begin
                        if (!bank_vld_q[wbank_q]) begin
                            sof_first_q <= VIN_SOF;
                            w_state_q   <= VIN_EOL ? W_IDLE : W_FILL;
                        end else begin
                            ovf_q     <= 1'b1;
                            w_state_q <= VIN_EOL ? W_IDLE : W_DROP;
                        end
                    end
                end
                W_FILL: begin
                    if (commit) begin
                        w_state_q <= W_IDLE;
                    end
                end
                W_DROP: begin
                    if (VIN_DE && VIN_EOL) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase

            if (pix_acc) begin
                if (word_done) begin
                    pack_q <= '0;
                    lane_q <= '0;
                    wcnt_q <= wcnt_d;
                    if (wcnt_q >= P_LINE_WORDS) begin
                        len_err_q <= 1'b1;
                    end
                end else begin
                    pack_q <= word_d;
                    lane_q <= lane_q + LANE_W'(1);
                end
            end

            // The write bank is always free here, so it never collides with
            // the head bank touched by the read side below.
            if (commit) begin
                bank_vld_q[wbank_q] <= 1'b1;
                bank_len_q[wbank_q] <= len_d;
                bank_sof_q[wbank_q] <= line_sof;
                wbank_q             <= ~wbank_q;
                wcnt_q              <= '0;
            end

            // ---------------- read side ----------------
            case (r_state_q)
                R_IDLE: begin
                    if (bank_vld_q[head_q]) begin
                        if (bank_sof_q[head_q]) begin
                            sof_q     <= 1'b1;
                            r_state_q <= R_SOF;
                        end else begin
                            st_q      <= 1'b1;
                            r_state_q <= R_RDY;
                        end
                    end
                end
                R_SOF: begin
                    sof_q              <= 1'b0;
                    st_q               <= 1'b1;
                    bank_sof_q[head_q] <= 1'b0;
                    r_state_q          <= R_RDY;
                end
                R_RDY: begin
                    if (CRP1_LBUF_REN) begin
                        rd_vld_q <= rd_in_range;
                        if (ridx_q != P_LINE_WORDS) begin
                            ridx_q <= ridx_q + 8'd1;
                        end
                    end
                    if (CRP1_LBUF_RCMP) begin
                        bank_vld_q[head_q] <= 1'b0;
                        ridx_q             <= '0;
                        head_q             <= ~head_q;
                        st_q               <= 1'b0;
                        r_state_q          <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

`ifdef CRP_LBUF_STAT_EN
    logic [15:0] drop_cnt_q;
    logic [11:0] line_cnt_q;

    always_ff @(posedge CLK_MIG1_UI) begin
        if (clr) begin
            drop_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            if ((w_state_q == W_IDLE) && VIN_DE && bank_vld_q[wbank_q] &&
                (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            // A committed SOF line starts a new frame count that includes it.
            if (commit) begin
                if (line_sof) begin
                    line_cnt_q <= 12'd1;
                end else if (line_cnt_q != 12'hFFF) begin
                    line_cnt_q <= line_cnt_q + 12'd1;
                end
            end
        end
    end

    assign LBUF_DROP_CNT = drop_cnt_q;
    assign LBUF_LINE_CNT = line_cnt_q;
`endif

    assign CRP1_SOF     = sof_q;
    assign CRP1_LBUF_ST = st_q;
    assign CRP1_LBUF_RD = rd_vld_q ? ram_rd_q : '0;
    assign LBUF_OVF     = ovf_q;
    assign LBUF_LEN_ERR = len_err_q;

endmodule

// File: tb/tb_crp_lbuf_pack.sv
// ---------------------------------------------------------------------------
// tb_crp_lbuf_pack
//
// Directed sequence with random pixel data, random line lengths and random
// DE gaps. The reference keeps a queue of stored lines, each held as the
// sixteen 512-bit words the consumer should read back, built directly from
// the pixel index arithmetic (pixel i -> word i/16, lane i%16).
// ---------------------------------------------------------------------------
module tb_crp_lbuf_pack;

    localparam int NWORDS  = 16;
    localparam int LINE_PX = NWORDS * 16;

    typedef logic [NWORDS-1:0][511:0] line_t;

    logic         clk = 1'b0;
    logic         RST = 1'b1;
    logic         REG_VACT_EN_MIG1 = 1'b1;
    logic         VIN_DE = 1'b0;
    logic         VIN_SOF = 1'b0;
    logic         VIN_EOL = 1'b0;
    logic [31:0]  VIN_DATA = '0;
    logic         CRP1_SOF;
    logic         CRP1_LBUF_ST;
    logic         CRP1_LBUF_REN = 1'b0;
    logic         CRP1_LBUF_RCMP = 1'b0;
    logic [511:0] CRP1_LBUF_RD;
    logic         LBUF_OVF;
    logic         LBUF_LEN_ERR;
`ifdef CRP_LBUF_STAT_EN
    logic [15:0]  LBUF_DROP_CNT;
    logic [11:0]  LBUF_LINE_CNT;
`endif

    crp_lbuf_pack #(.P_SIM(1'b1)) dut (
        .CLK_MIG1_UI      (clk),
        .RST              (RST),
        .REG_VACT_EN_MIG1 (REG_VACT_EN_MIG1),
        .VIN_DE           (VIN_DE),
        .VIN_SOF          (VIN_SOF),
        .VIN_EOL          (VIN_EOL),
        .VIN_DATA         (VIN_DATA),
        .CRP1_SOF         (CRP1_SOF),
        .CRP1_LBUF_ST     (CRP1_LBUF_ST),
        .CRP1_LBUF_REN    (CRP1_LBUF_REN),
        .CRP1_LBUF_RCMP   (CRP1_LBUF_RCMP),
        .CRP1_LBUF_RD     (CRP1_LBUF_RD),
        .LBUF_OVF         (LBUF_OVF),
`ifdef CRP_LBUF_STAT_EN
        .LBUF_DROP_CNT    (LBUF_DROP_CNT),
        .LBUF_LINE_CNT    (LBUF_LINE_CNT),
`endif
        .LBUF_LEN_ERR     (LBUF_LEN_ERR)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    line_t exp_q[$];
    bit    exp_sq[$];
    bit    exp_ovf = 1'b0;
    bit    exp_len_err = 1'b0;
    int    exp_sof_total = 0;

    // SOF pulse monitor: counts pulses, pulses seen together with ST, and
    // pulses longer than one cycle.
    int   sof_cnt = 0;
    int   sof_with_st = 0;
    int   sof_long = 0;
    logic prev_sof = 1'b0;

    always @(posedge clk) begin
        prev_sof <= CRP1_SOF;
        if (CRP1_SOF === 1'b1) begin
            sof_cnt <= sof_cnt + 1;
            if (CRP1_LBUF_ST !== 1'b0) sof_with_st <= sof_with_st + 1;
            if (prev_sof === 1'b1)     sof_long    <= sof_long + 1;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one line starting at the current negedge.
    task automatic send_line(input int n, input bit sof, input bit gaps);
        logic [31:0] px;
        line_t       ln;
        bit          store;
        store = (exp_q.size() < 2);
        ln    = '0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                VIN_DE = 1'b0; VIN_SOF = 1'b0; VIN_EOL = 1'b0;
                @(negedge clk);
            end
            px       = $urandom;
            VIN_DE   = 1'b1;
            VIN_SOF  = sof && (i == 0);
            VIN_EOL  = (i == n - 1);
            VIN_DATA = px;
            if (i < LINE_PX) ln[i / 16][32 * (i % 16) +: 32] = px;
            @(negedge clk);
        end
        VIN_DE = 1'b0; VIN_SOF = 1'b0; VIN_EOL = 1'b0;
        if (store) begin
            exp_q.push_back(ln);
            exp_sq.push_back(sof);
        end else begin
            exp_ovf = 1'b1;
        end
        if (n > LINE_PX) exp_len_err = 1'b1;
        $display("tx line px=%0d sof=%0d stored=%0d", n, sof, store);
        chk("ovf", LBUF_OVF, exp_ovf);
        chk("len_err", LBUF_LEN_ERR, exp_len_err);
    endtask

    task automatic wait_st(output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        chk("model_has_line", exp_q.size() != 0, 1'b1);
        if (exp_q.size() == 0) return;
        while (CRP1_LBUF_ST !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("st_timeout", t < 400, 1'b1);
        if (t >= 400) return;
        if (exp_sq[0]) exp_sof_total++;
        chk("sof_count", sof_cnt, exp_sof_total);
        ok = 1'b1;
    endtask

    // Reads the head line; mid_n > 0 sends a SOF line halfway through the read.
    task automatic read_line(input int mid_n, input bit extra);
        line_t ln;
        bit    ok;
        wait_st(ok);
        if (!ok) return;
        ln = exp_q[0];
        for (int w = 0; w < NWORDS; w++) begin
            if (w == NWORDS / 2 && mid_n > 0) begin
                CRP1_LBUF_REN = 1'b0;
                send_line(mid_n, 1'b1, 1'b0);
                chk("sof_held_while_draining", sof_cnt, exp_sof_total);
                chk("st_held_while_draining", CRP1_LBUF_ST, 1'b1);
            end
            CRP1_LBUF_REN = 1'b1;
            @(negedge clk);
            chk($sformatf("rd_w%0d", w), CRP1_LBUF_RD, ln[w]);
        end
        if (extra) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk($sformatf("rd_past_end%0d", k), CRP1_LBUF_RD, '0);
            end
        end
        CRP1_LBUF_REN  = 1'b0;
        CRP1_LBUF_RCMP = 1'b1;
        @(negedge clk);
        CRP1_LBUF_RCMP = 1'b0;
        chk("st_after_rcmp", CRP1_LBUF_ST, 1'b0);
        $display("rx line sof=%0d words=%0d", exp_sq[0], NWORDS);
        void'(exp_q.pop_front());
        void'(exp_sq.pop_front());
    endtask

    initial begin
        bit ok;
        int n;
        bit s;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_sof", CRP1_SOF, 1'b0);
        chk("rst_st", CRP1_LBUF_ST, 1'b0);
        chk("rst_rd", CRP1_LBUF_RD, '0);
        chk("rst_ovf", LBUF_OVF, 1'b0);
        chk("rst_len_err", LBUF_LEN_ERR, 1'b0);
        RST = 1'b0;
        @(negedge clk);

        // REN/RCMP with nothing buffered are ignored
        CRP1_LBUF_REN = 1'b1; CRP1_LBUF_RCMP = 1'b1;
        @(negedge clk);
        CRP1_LBUF_REN = 1'b0; CRP1_LBUF_RCMP = 1'b0;
        @(negedge clk);
        chk("idle_st", CRP1_LBUF_ST, 1'b0);
        chk("idle_rd", CRP1_LBUF_RD, '0);

        // Frame of 4 full lines, consumer always ready
        for (int l = 0; l < 4; l++) begin
            send_line(LINE_PX, l == 0, 1'b1);
            read_line(0, 1'b0);
        end

        // Short line with zero padding and reads past the end
        send_line(20, 1'b0, 1'b0);
        read_line(0, 1'b1);

        // Consumer stalled: two stored, third dropped; fourth starts the
        // cycle after the first RCMP
        send_line(LINE_PX, 1'b0, 1'b0);
        send_line(100, 1'b0, 1'b1);
        send_line(LINE_PX, 1'b0, 1'b0);
        read_line(0, 1'b0);
        send_line(50, 1'b0, 1'b0);
        read_line(0, 1'b0);
        read_line(0, 1'b0);

        // Over-long line then a normal one
        send_line(300, 1'b0, 1'b1);
        read_line(0, 1'b1);
        send_line(100, 1'b0, 1'b0);
        read_line(0, 1'b0);

        // Next frame's SOF line arrives while the head is being drained
        send_line(LINE_PX, 1'b0, 1'b0);
        read_line(LINE_PX, 1'b0);
        read_line(0, 1'b0);

        // Flush mid-line with ST, RD and both sticky flags set
        send_line(64, 1'b0, 1'b0);
        wait_st(ok);
        if (ok) begin
            CRP1_LBUF_REN = 1'b1;
            @(negedge clk);
            CRP1_LBUF_REN = 1'b0;
            chk("rd_before_flush", CRP1_LBUF_RD, exp_q[0][0]);
        end
        for (int i = 0; i < 40; i++) begin
            VIN_DE = 1'b1; VIN_DATA = $urandom;
            @(negedge clk);
        end
        chk("ovf_before_flush", LBUF_OVF, exp_ovf);
        VIN_DE = 1'b0;
        REG_VACT_EN_MIG1 = 1'b0;
        @(negedge clk);
        REG_VACT_EN_MIG1 = 1'b1;
        chk("flush_sof", CRP1_SOF, 1'b0);
        chk("flush_st", CRP1_LBUF_ST, 1'b0);
        chk("flush_rd", CRP1_LBUF_RD, '0);
        chk("flush_ovf", LBUF_OVF, 1'b0);
        chk("flush_len_err", LBUF_LEN_ERR, 1'b0);
        exp_q.delete();
        exp_sq.delete();
        exp_ovf = 1'b0;
        exp_len_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_st_stays_low", CRP1_LBUF_ST, 1'b0);

        // Clean restart, including a single-pixel SOF line
        send_line(LINE_PX, 1'b1, 1'b1);
        read_line(0, 1'b0);
        send_line(1, 1'b1, 1'b0);
        read_line(0, 1'b1);

        // Random lines
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 300);
            s = ($urandom_range(0, 3) == 0);
            send_line(n, s, 1'b1);
            read_line(0, k[0]);
        end

        repeat (2) @(negedge clk);
        chk("sof_never_with_st", sof_with_st, 0);
        chk("sof_single_cycle", sof_long, 0);
        chk("sof_total", sof_cnt, exp_sof_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
